// File: rtl/verifla_uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | verifla_uart_pkg : shared states and timing constants for the UART |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package verifla_uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int HALF_BIT   = 8;
    localparam int TICK_W     = $clog2(OVERSAMPLE);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

    function automatic int calc_div_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage
`default_nettype wire

// File: rtl/verifla_uart_if.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | verifla_uart_if : host byte port plus serial pins of the UART      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface verifla_uart_if;
    logic [7:0] data_i;
    logic       wen_i;
    logic       txd_o;
    logic       tre_o;
    logic       rxd_i;
    logic [7:0] data_o;
    logic       rdy_o;
    logic       baud_tick_o;

    modport master (
        output data_i, wen_i, rxd_i,
        input  txd_o, tre_o, data_o, rdy_o, baud_tick_o
    );

    modport slave (
        input  data_i, wen_i, rxd_i,
        output txd_o, tre_o, data_o, rdy_o, baud_tick_o
    );
endinterface
`default_nettype wire

// File: rtl/verifla_uart_baud_tick.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | verifla_uart_baud_tick : free-running divider, one-cycle tick      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module verifla_uart_baud_tick #(
    parameter int DIV   = 54,
    parameter int DIV_W = 6
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam logic [DIV_W-1:0] C_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (r_cnt == C_LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign tick = (r_cnt == C_LAST);
endmodule
`default_nettype wire

// File: rtl/verifla_uart.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | verifla_uart : 8N1 UART, independent TX/RX on a shared 16x tick    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module verifla_uart
    import verifla_uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic          sys_clk,
    input  logic          sys_rst_l,
    verifla_uart_if.slave bus
);
    localparam int DIV   = calc_div(CLK_FREQ, BAUD);
    localparam int DIV_W = calc_div_width(DIV);
    localparam logic [TICK_W-1:0] C_LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] C_MID_TICK  = TICK_W'(HALF_BIT - 1);

    logic w_tick;

    verifla_uart_baud_tick #(.DIV(DIV), .DIV_W(DIV_W)) u_baud (
        .clk   (sys_clk),
        .rst_n (sys_rst_l),
        .tick  (w_tick)
    );

    // ---------------- transmitter ----------------
    tx_state_t         r_tx_state;
    logic [TICK_W-1:0] r_tx_cnt;
    logic [2:0]        r_tx_bit;
    logic [7:0]        r_tx_shift;
    logic              r_txd;
    logic              r_tre;

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
            r_tre      <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_txd <= 1'b1;
                    if (bus.wen_i && r_tre) begin
                        r_tx_shift <= bus.data_i;
                        r_tx_cnt   <= '0;
                        r_tre      <= 1'b0;
                        r_txd      <= 1'b0;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: if (w_tick) begin
                    if (r_tx_cnt == C_LAST_TICK) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_txd      <= r_tx_shift[0];
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_DATA: if (w_tick) begin
                    if (r_tx_cnt == C_LAST_TICK) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_txd      <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            // shift now, present the next bit from the pre-shift value
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_txd      <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_STOP: if (w_tick) begin
                    if (r_tx_cnt == C_LAST_TICK) begin
                        r_tx_cnt   <= '0;
                        r_tre      <= 1'b1;
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    rx_state_t         r_rx_state;
    logic [TICK_W-1:0] r_rx_cnt;
    logic [2:0]        r_rx_bit;
    logic [7:0]        r_rx_shift;
    logic [7:0]        r_rx_data;
    logic              r_rdy;
    logic              r_rx_ferr;
    logic              r_rx_meta;
    logic              r_rx_sync;

    // Synchronizer resets to the idle level so reset release cannot fake a start bit
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= bus.rxd_i;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rdy      <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            case (r_rx_state)
                RX_IDLE: if (!r_rx_sync) begin
                    r_rx_cnt   <= '0;
                    r_rx_state <= RX_START;
                end
                RX_START: if (w_tick) begin
                    if (r_rx_cnt == C_MID_TICK) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_DATA: if (w_tick) begin
                    if (r_rx_cnt == C_LAST_TICK) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 1'b1;
                        if (r_rx_bit == 3'd7)
                            r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    // after a framing error, hold here until the line returns high
                    if (r_rx_ferr) begin
                        if (r_rx_sync) begin
                            r_rx_ferr  <= 1'b0;
                            r_rx_state <= RX_IDLE;
                        end
                    end else if (w_tick) begin
                        if (r_rx_cnt == C_LAST_TICK) begin
                            r_rx_cnt <= '0;
                            if (r_rx_sync) begin
                                r_rx_data  <= r_rx_shift;
                                r_rdy      <= 1'b1;
                                r_rx_state <= RX_IDLE;
                            end else begin
                                r_rx_ferr <= 1'b1;
                            end
                        end else begin
                            r_rx_cnt <= r_rx_cnt + 1'b1;
                        end
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign bus.txd_o       = r_txd;
    assign bus.tre_o       = r_tre;
    assign bus.data_o      = r_rx_data;
    assign bus.rdy_o       = r_rdy;
    assign bus.baud_tick_o = w_tick;
endmodule
`default_nettype wire

// File: tb/tb_verifla_uart.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for verifla_uart: loopback vectors plus directed
// sequences for timing, back-to-back, busy-write, glitch and framing cases.
module tb_verifla_uart;

    localparam int DIV = 54;
    localparam int BIT = 864;
    localparam int WAVE_LEN = 9000;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] exp_data;
        int         exp_rdy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       loop_en = 1'b1;
    logic       rxd_drv = 1'b1;
    int         n_checks = 0;
    int         n_errors = 0;
    int         rdy_cnt = 0;
    logic [7:0] rx_q[$];
    logic       wave [0:WAVE_LEN-1];

    verifla_uart_if bus();
    assign bus.rxd_i = loop_en ? bus.txd_o : rxd_drv;

    verifla_uart dut (
        .sys_clk   (clk),
        .sys_rst_l (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rdy_o) begin
            rdy_cnt++;
            rx_q.push_back(bus.data_o);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_rx();
        rdy_cnt = 0;
        rx_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        bus.data_i = b;
        bus.wen_i  = 1'b1;
        cycles(hold);
        bus.wen_i  = 1'b0;
    endtask

    task automatic wait_tre_high(input string name, input int limit);
        int n = 0;
        while (!bus.tre_o && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, bus.tre_o, 1'b1);
    endtask

    task automatic wait_rdy(input string name, input int target, input int limit);
        int n = 0;
        while (rdy_cnt < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, rdy_cnt, target);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxd_drv = f[k];
            cycles(BIT);
        end
    endtask

    function automatic logic [7:0] q_at(input int idx);
        return (idx < rx_q.size()) ? rx_q[idx] : 8'hxx;
    endfunction

    vec_t vecs[2];

    initial begin
        int         n;
        int         s_end;
        int         tre_rise;
        int         rdy_idx;
        logic [8:0] exp9;

        vecs[0] = '{tx: 8'h5A, exp_data: 8'h5A, exp_rdy: 1};
        vecs[1] = '{tx: 8'h81, exp_data: 8'h81, exp_rdy: 1};

        bus.data_i = 8'h00;
        bus.wen_i  = 1'b0;

        // Reset held for 2 us
        cycles(200);
        check("rst_baud_tick", bus.baud_tick_o, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_txd", bus.txd_o, 1'b1);
        check("rst_tre", bus.tre_o, 1'b1);
        check("rst_rdy", bus.rdy_o, 1'b0);
        check("rst_data", bus.data_o, 8'h00);

        // Baud tick period
        n = 0;
        while (!bus.baud_tick_o && n < 200) begin @(negedge clk); n++; end
        for (int p = 0; p < 2; p++) begin
            n = 0;
            @(negedge clk); n++;
            while (!bus.baud_tick_o && n < 200) begin @(negedge clk); n++; end
            check("baud_period", n, DIV);
        end

        // Loopback 0x61 with wen held for 200 cycles, waveform recorded
        cycles(400);
        clear_rx();
        bus.data_i = 8'h61;
        bus.wen_i  = 1'b1;
        tre_rise = -1;
        rdy_idx  = -1;
        @(negedge clk);
        check("lb_tre_fall", bus.tre_o, 1'b0);
        for (int i = 0; i < WAVE_LEN; i++) begin
            wave[i] = bus.txd_o;
            if (bus.tre_o && tre_rise < 0) tre_rise = i;
            if (rdy_cnt > 0 && rdy_idx < 0) rdy_idx = i;
            if (i == 198) bus.wen_i = 1'b0;
            @(negedge clk);
        end
        s_end = -1;
        for (int i = 0; i < WAVE_LEN; i++)
            if (wave[i] && s_end < 0) s_end = i;
        check_range("lb_start_len", s_end, 15*DIV + 1, 16*DIV + 1);
        if (s_end < 0) s_end = 0;
        check("lb_start_bit", wave[0], 1'b0);
        exp9 = {1'b1, 8'h61};
        for (int k = 0; k < 9; k++)
            check($sformatf("lb_bit%0d", k), wave[s_end + BIT/2 + k*BIT], exp9[k]);
        check("lb_tre_rise_rel", tre_rise - s_end, 9*BIT);
        check_range("lb_tre_rise", tre_rise, 10*BIT - DIV, 10*BIT + 1);
        check_range("lb_rdy_time", rdy_idx, 8100, 8300);
        check("lb_rdy_count", rdy_cnt, 1);
        check("lb_data", bus.data_o, 8'h61);

        // Table-driven loopback vectors
        foreach (vecs[v]) begin
            clear_rx();
            send_byte(vecs[v].tx, 1);
            wait_rdy($sformatf("vec%0d_rdy", v), vecs[v].exp_rdy, 10*BIT + 200);
            wait_tre_high($sformatf("vec%0d_tre", v), 10*BIT);
            check($sformatf("vec%0d_data", v), bus.data_o, vecs[v].exp_data);
            check($sformatf("vec%0d_q", v), q_at(0), vecs[v].exp_data);
        end

        // Back-to-back 0x00 then 0xFF written on tre rising
        cycles(100);
        clear_rx();
        send_byte(8'h00, 1);
        wait_tre_high("b2b_tre1", 10*BIT + 100);
        bus.data_i = 8'hFF;
        bus.wen_i  = 1'b1;
        @(negedge clk);
        bus.wen_i  = 1'b0;
        check("b2b_accept", bus.tre_o, 1'b0);
        wait_rdy("b2b_rdy", 2, 10*BIT + 200);
        check("b2b_q0", q_at(0), 8'h00);
        check("b2b_q1", q_at(1), 8'hFF);
        wait_tre_high("b2b_tre2", 10*BIT);

        // Write while busy is ignored
        cycles(100);
        clear_rx();
        send_byte(8'hA3, 1);
        cycles(3000);
        send_byte(8'h55, 1);
        check("busy_tre", bus.tre_o, 1'b0);
        wait_rdy("busy_rdy", 1, 10*BIT);
        wait_tre_high("busy_tre_rise", 10*BIT);
        cycles(300);
        check("busy_idle_tre", bus.tre_o, 1'b1);
        check("busy_idle_txd", bus.txd_o, 1'b1);
        check("busy_rdy_count", rdy_cnt, 1);
        check("busy_data", bus.data_o, 8'hA3);

        // Glitch on rxd shorter than half a bit
        loop_en = 1'b0;
        rxd_drv = 1'b1;
        cycles(100);
        clear_rx();
        rxd_drv = 1'b0;
        cycles(3*DIV);
        rxd_drv = 1'b1;
        cycles(20*DIV);
        check("glitch_rdy", rdy_cnt, 0);
        check("glitch_data", bus.data_o, 8'hA3);

        // Framing error then a valid 0x3C frame
        drive_frame(8'h96, 1'b0);
        rxd_drv = 1'b0;
        cycles(BIT);
        rxd_drv = 1'b1;
        cycles(2*BIT);
        check("ferr_rdy", rdy_cnt, 0);
        check("ferr_data", bus.data_o, 8'hA3);
        drive_frame(8'h3C, 1'b1);
        wait_rdy("ferr_next_rdy", 1, 2*BIT);
        check("ferr_next_data", bus.data_o, 8'h3C);
        check("ferr_next_q", q_at(0), 8'h3C);

        // Asynchronous reset mid-frame
        loop_en = 1'b1;
        cycles(100);
        send_byte(8'h00, 1);
        cycles(2000);
        check("midrst_pre_txd", bus.txd_o, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_txd", bus.txd_o, 1'b1);
        check("midrst_tre", bus.tre_o, 1'b1);
        check("midrst_data", bus.data_o, 8'h00);
        cycles(10);
        rst_n = 1'b1;
        cycles(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/verifla_uart.md
Name: verifla_uart

Overview:
- Self-contained 8N1 UART: baud-tick generator, transmitter and receiver sharing one 16x-oversampling tick.
- Sits between a byte-wide host interface (logic-analyzer capture/readout path) and the serial pins.
- Transmitter and receiver are independent, so `txd_o` may be looped to `rxd_i` for self-test.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- OVERSAMPLE, 16, ticks per bit period.
- DIV, CLK_FREQ/(BAUD*OVERSAMPLE) integer-truncated (54 at defaults), clock cycles per tick. Derived; not overridden.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst_l  in  1  asynchronous, active-low reset.
- data_i  in  8  byte to transmit.
- wen_i  in  1  write enable for `data_i`.
- txd_o  out  1  serial output, idle high.
- tre_o  out  1  transmitter empty; 1 = ready to accept a byte.
- rxd_i  in  1  serial input, asynchronous to `sys_clk`.
- data_o  out  8  last correctly received byte.
- rdy_o  out  1  one-cycle pulse: `data_o` just updated.
- baud_tick_o  out  1  one-cycle tick at BAUD*OVERSAMPLE rate; observation only.

Behaviour:
- Reset values (`sys_rst_l`=0, asynchronous): `txd_o`=1, `tre_o`=1, `data_o`=0, `rdy_o`=0, `baud_tick_o`=0, all counters 0, both FSMs IDLE.
- Baud generator:
  - Counter runs 0..DIV-1.
  - `baud_tick_o`=1 for exactly the one cycle when the counter equals DIV-1, then the counter wraps to 0.
  - Free-running after reset; never gated by TX/RX.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: `txd_o`=1, `tre_o`=1.
  - When `wen_i`=1 and `tre_o`=1: latch `data_i` into a shift register, drive `tre_o`=0 on the next cycle, go to START.
  - `wen_i` is ignored while `tre_o`=0.
  - `wen_i` is level-sensitive: if still high when the frame ends, a new frame starts with the current `data_i`.
  - Bit timing advances only on ticks. Each bit lasts 16 ticks; the first bit boundary is the first tick after the latch.
  - START drives 0. DATA drives bits 0..7, LSB first. STOP drives 1.
  - After the 16th stop-bit tick: `tre_o`=1, return to IDLE.
  - Frame length: 160 ticks, 8640 cycles at defaults.
- RX FSM states: IDLE, START, DATA, STOP.
  - `rxd_i` passes through a 2-flop synchronizer; all RX decisions use the synchronized value.
  - IDLE: on a synchronized low, clear the tick counter and go to START.
  - START: after 8 ticks (mid start bit), re-sample. If still 0, clear the counter and go to DATA. If 1, treat as a glitch and return to IDLE.
  - DATA: every 16 ticks sample one bit into a shift register, LSB first; 8 bits.
  - STOP: 16 ticks later sample the stop bit.
    - If 1: load `data_o` with the shift register, pulse `rdy_o` for exactly one `sys_clk` cycle, go to IDLE.
    - If 0 (framing error): discard the byte, no `rdy_o`, `data_o` unchanged; wait in STOP until the line is high, then IDLE.
- `data_o` holds its value until the next good frame.
- Reset mid-frame aborts both FSMs immediately; `txd_o` returns high with no partial-stop behaviour.
- TX and RX may operate simultaneously with no interaction.

Decomposition:
- Package `verifla_uart_pkg`:
  - TX and RX state enums.
  - OVERSAMPLE and the half-bit constant (8).
  - Function computing DIV and its counter width.
- One sub-module, `verifla_uart_baud_tick`, holds the divider.
- TX and RX FSMs live in the top module.

Test Plan:
- Reset: hold `sys_rst_l`=0 for 2 µs, then release → `txd_o`=1, `tre_o`=1, `rdy_o`=0, `data_o`=0x00. `baud_tick_o` period is 54 cycles.
- Loopback 0x61 (`txd_o` tied to `rxd_i`): release reset, wait 4 µs, set `data_i`=0x61 with `wen_i`=1 for 200 cycles → the following are all required:
  - `tre_o` falls within 1 cycle.
  - `txd_o` shows 0,1,0,0,0,0,1,1,0,1, each 864 cycles.
  - `rdy_o` pulses once, about 82 µs after the start bit begins.
  - `data_o`=0x61.
  - `tre_o` rises after 8640 cycles.
- Back-to-back: write 0x00 then 0xFF on `tre_o` rising → two `rdy_o` pulses, `data_o` 0x00 then 0xFF; no extra idle beyond one tick.
- Busy write: pulse `wen_i` with 0x55 mid-frame of 0xA3 → only 0xA3 transmitted and received.
- Glitch: drive `rxd_i` low for 3 ticks, then high → no `rdy_o`, RX back in IDLE.
- Framing error: send a frame with stop bit 0 into `rxd_i` → no `rdy_o`, `data_o` unchanged; the next valid frame 0x3C is received correctly.
